// File: rtl/clint_timer_if.sv
// Request/response port of the core-local interruptor.
// One transfer occurs on each edge where valid && ready; the initiator holds its payload stable while valid is high.
interface clint_timer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_strb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/clint_timer.sv
// Core-local interruptor: the mtime counter with a prescaler, mtimecmp, and msip.
// It drives mtip and msip into the CSR unit.
module clint_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  clint_timer_if.slave bus,
  output logic         msip,
  output logic         mtip,
  output logic         dbg_state
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [15:0] div_cnt;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;
  logic        req_ready_c;
  logic        resp_valid_c;

  logic        accept;
  logic        tick;
  logic        sel_msip, sel_cmp, sel_time, hit;
  logic [63:0] rd_data;
  logic [63:0] wmask;

  function automatic logic [63:0] byte_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  // Full 16-bit matches, so any misaligned offset is treated as unmapped.
  assign sel_msip = (bus.req_addr == 16'h0000);
  assign sel_cmp  = (bus.req_addr == 16'h4000);
  assign sel_time = (bus.req_addr == 16'hBFF8);
  assign hit      = sel_msip | sel_cmp | sel_time;
  assign wmask    = byte_mask(bus.req_strb);
  assign accept   = (state == IDLE) && bus.req_valid;
  assign tick     = (div_cnt == 16'(TICK_DIV - 1));

  always_comb begin
    rd_data = 64'd0;
    if (!bus.req_write) begin
      if (sel_msip)      rd_data = {63'd0, msip};
      else if (sel_cmp)  rd_data = mtimecmp;
      else if (sel_time) rd_data = mtime;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready_c  = 1'b0;
    resp_valid_c = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) state_nxt = RESP;
      end
      RESP: begin
        resp_valid_c = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The prescaler runs freely; a software write to mtime never realigns it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_cnt <= 16'd0;
    else if (tick) div_cnt <= 16'd0;
    else div_cnt <= div_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtime <= 64'd0;
    end else if (accept && bus.req_write && sel_time) begin
      mtime <= (mtime & ~wmask) | (bus.req_wdata & wmask);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip     <= 1'b0;
    end else if (accept && bus.req_write) begin
      if (sel_cmp)                    mtimecmp <= (mtimecmp & ~wmask) | (bus.req_wdata & wmask);
      if (sel_msip && bus.req_strb[0]) msip    <= bus.req_wdata[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mtip <= 1'b0;
    else          mtip <= (mtime >= mtimecmp);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
    end else if (accept) begin
      resp_rdata_q <= rd_data;
      resp_err_q   <= !hit;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign dbg_state      = logic'(state);

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV 1 and 4) share one stimulus stream.
// Each instance is compared against its own instance of a behavioural register-map model.
module tb_clint_timer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr  = 16'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [7:0]  req_strb  = 8'd0;
  logic        resp_ready = 1'b0;

  clint_timer_if bus1();
  clint_timer_if bus4();
  logic msip1, mtip1, dbg1, msip4, mtip4, dbg4;

  assign bus1.req_valid  = req_valid;
  assign bus1.req_write  = req_write;
  assign bus1.req_addr   = req_addr;
  assign bus1.req_wdata  = req_wdata;
  assign bus1.req_strb   = req_strb;
  assign bus1.resp_ready = resp_ready;
  assign bus4.req_valid  = req_valid;
  assign bus4.req_write  = req_write;
  assign bus4.req_addr   = req_addr;
  assign bus4.req_wdata  = req_wdata;
  assign bus4.req_strb   = req_strb;
  assign bus4.resp_ready = resp_ready;

  clint_timer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1),
    .msip(msip1), .mtip(mtip1), .dbg_state(dbg1)
  );
  clint_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4),
    .msip(msip4), .mtip(mtip4), .dbg_state(dbg4)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: the tick schedule follows from the cycle count since reset, and registers are plain variables.
  logic [63:0] m_time[2], m_cmp[2], m_rdata[2];
  logic        m_msip[2], m_mtip[2], m_err[2];
  logic        m_busy;
  logic        m_acc, m_hit, m_mtip_n;
  logic [63:0] m_old_time, m_old_cmp;
  int unsigned edge_k;

  function automatic int unsigned div_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_k = 0;
      m_busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_time[i] = 64'd0; m_cmp[i] = '1; m_rdata[i] = 64'd0;
        m_msip[i] = 1'b0;  m_mtip[i] = 1'b0; m_err[i] = 1'b0;
      end
    end else begin
      edge_k = edge_k + 1;
      m_acc  = !m_busy && req_valid;
      m_hit  = (req_addr == 16'h0000) || (req_addr == 16'h4000) || (req_addr == 16'hBFF8);
      for (int i = 0; i < 2; i++) begin
        m_old_time = m_time[i];
        m_old_cmp  = m_cmp[i];
        m_mtip_n   = (m_old_time >= m_old_cmp);
        if (m_acc) begin
          m_err[i]   = !m_hit;
          m_rdata[i] = 64'd0;
          if (!req_write) begin
            if (req_addr == 16'h0000)      m_rdata[i] = {63'd0, m_msip[i]};
            else if (req_addr == 16'h4000) m_rdata[i] = m_old_cmp;
            else if (req_addr == 16'hBFF8) m_rdata[i] = m_old_time;
          end else begin
            if (req_addr == 16'h0000 && req_strb[0]) m_msip[i] = req_wdata[0];
            if (req_addr == 16'h4000) m_cmp[i] = merge(m_old_cmp, req_wdata, req_strb);
          end
        end
        if (m_acc && req_write && req_addr == 16'hBFF8)
          m_time[i] = merge(m_old_time, req_wdata, req_strb);
        else if ((edge_k % div_of(i)) == 0)
          m_time[i] = m_old_time + 64'd1;
        m_mtip[i] = m_mtip_n;
      end
      if (m_busy && resp_ready) m_busy = 1'b0;
      else if (m_acc)           m_busy = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":rdy1"},  {63'd0, bus1.req_ready},  {63'd0, !m_busy});
    chk({tag, ":rv1"},   {63'd0, bus1.resp_valid}, {63'd0, m_busy});
    chk({tag, ":msip1"}, {63'd0, msip1},           {63'd0, m_msip[0]});
    chk({tag, ":mtip1"}, {63'd0, mtip1},           {63'd0, m_mtip[0]});
    chk({tag, ":rdy4"},  {63'd0, bus4.req_ready},  {63'd0, !m_busy});
    chk({tag, ":rv4"},   {63'd0, bus4.resp_valid}, {63'd0, m_busy});
    chk({tag, ":msip4"}, {63'd0, msip4},           {63'd0, m_msip[1]});
    chk({tag, ":mtip4"}, {63'd0, mtip4},           {63'd0, m_mtip[1]});
    if (m_busy) begin
      chk({tag, ":rd1"},  bus1.resp_rdata,        m_rdata[0]);
      chk({tag, ":err1"}, {63'd0, bus1.resp_err}, {63'd0, m_err[0]});
      chk({tag, ":rd4"},  bus4.resp_rdata,        m_rdata[1]);
      chk({tag, ":err4"}, {63'd0, bus4.resp_err}, {63'd0, m_err[1]});
    end
  endtask

  task automatic cyc(input string tag);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) cyc(tag);
  endtask

  task automatic txn(input logic w, input logic [15:0] a, input logic [63:0] d,
                     input logic [7:0] s, input int hold, input string tag);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
    cyc({tag, ".acc"});
    req_valid = 1'b0;
    repeat (hold) cyc({tag, ".hold"});
    resp_ready = 1'b1;
    cyc({tag, ".done"});
    resp_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset.rd1",  bus1.resp_rdata, 64'd0);
    chk("reset.err1", {63'd0, bus1.resp_err}, 64'd0);
    reset_n = 1'b1;
    idle(10, "idle");

    // First read of mtime after ten idle edges: accepted on edge 11.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hBFF8; req_strb = 8'h00;
    cyc("t0.acc");
    req_valid = 1'b0;
    chk("t0.mtime1", bus1.resp_rdata, 64'd10);
    chk("t0.mtime4", bus4.resp_rdata, 64'd2);
    chk("t0.err1", {63'd0, bus1.resp_err}, 64'd0);
    resp_ready = 1'b1;
    cyc("t0.done");
    resp_ready = 1'b0;

    txn(1'b1, 16'h4000, 64'd20, 8'hFF, 0, "cmp20");
    idle(12, "cmp_wait");
    chk("cmp20.mtip1", {63'd0, mtip1}, 64'd1);
    txn(1'b1, 16'h4000, '1, 8'hFF, 0, "cmp_ones");
    idle(2, "cmp_fall");
    chk("cmp_ones.mtip1", {63'd0, mtip1}, 64'd0);

    txn(1'b1, 16'h0000, 64'h3, 8'h01, 0, "msip_set");
    chk("msip_set.msip1", {63'd0, msip1}, 64'd1);
    txn(1'b0, 16'h0000, 64'h0, 8'h00, 1, "msip_rd");
    txn(1'b1, 16'h0000, 64'h0, 8'h01, 0, "msip_clr");
    chk("msip_clr.msip4", {63'd0, msip4}, 64'd0);

    txn(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, "wrap");
    idle(9, "wrap_wait");
    txn(1'b0, 16'hBFF8, 64'h0, 8'h00, 0, "wrap_rd");

    txn(1'b0, 16'h0004, 64'h0, 8'h00, 5, "err_mis");
    txn(1'b0, 16'h1000, 64'h0, 8'h00, 5, "err_unm");
    txn(1'b1, 16'h4004, '1, 8'hFF, 0, "err_wr");
    txn(1'b0, 16'h4000, 64'h0, 8'h00, 0, "cmp_rd");
    txn(1'b1, 16'h4000, 64'h0000_0000_1234_5678, 8'h0F, 0, "cmp_part");
    txn(1'b0, 16'h4000, 64'h0, 8'h00, 2, "cmp_part_rd");

    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      case ($urandom_range(0, 5))
        0: a = 16'h0000;
        1: a = 16'h4000;
        2: a = 16'hBFF8;
        3: a = 16'h0004;
        4: a = 16'h1000;
        default: a = 16'($urandom);
      endcase
      txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
          $urandom_range(0, 3), "rand");
      idle($urandom_range(0, 3), "rand_gap");
    end

    // Reset asserted while a read response is pending.
    txn(1'b1, 16'hBFF8, 64'd500, 8'hFF, 0, "pre_rst_t");
    txn(1'b1, 16'h4000, 64'd400, 8'hFF, 0, "pre_rst_c");
    txn(1'b1, 16'h0000, 64'd1, 8'h01, 0, "pre_rst_m");
    idle(2, "pre_rst_idle");
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hBFF8; req_strb = 8'h00;
    cyc("rst_rd.acc");
    req_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_all("midrst");
    chk("midrst.rv1",   {63'd0, bus1.resp_valid}, 64'd0);
    chk("midrst.rdy4",  {63'd0, bus4.req_ready},  64'd1);
    chk("midrst.rd1",   bus1.resp_rdata,          64'd0);
    chk("midrst.err4",  {63'd0, bus4.resp_err},   64'd0);
    chk("midrst.msip1", {63'd0, msip1},           64'd0);
    chk("midrst.mtip1", {63'd0, mtip1},           64'd0);
    idle(2, "in_rst");
    reset_n = 1'b1;
    idle(3, "post_rst");
    txn(1'b0, 16'hBFF8, 64'h0, 8'h00, 0, "post_rst_rd");
    txn(1'b0, 16'h4000, 64'h0, 8'h00, 0, "post_rst_cmp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
